multi_square_object: RTL
========================

// Module: multi_square_object
//
// PURPOSE
// Renders up to NUM_OBJ same-size rectangular brackets from one instance, replacing one single-object bracket block per object.
// Object positions are shadowed at frame start, so mid-frame position updates never tear.
// Overlapping objects resolve by fixed priority: the lowest index wins.
// Also reports per-pixel and per-frame overlap, which collision logic consumes. Sits between game-object position logic and the VGA object mux.
//
// PARAMETERS
// NUM_OBJ        4         number of objects (1..16)
// OBJECT_WIDTH_X 100       bracket width in pixels (1..1023)
// OBJECT_HEIGHT_Y 100      bracket height in pixels (1..1023)
// OBJECT_COLOR   8'h03     RGBout value when any object is hit
//
// PORTS
// clk            in   1            pixel clock
// resetN         in   1            async active-low reset
// startOfFrame   in   1            1-cycle strobe: latch positions, roll frame overlap
// pixelX         in   11 signed    current VGA pixel X
// pixelY         in   11 signed    current VGA pixel Y
// topLeftX       in   [NUM_OBJ][11] signed   live object X positions (may be negative)
// topLeftY       in   [NUM_OBJ][11] signed   live object Y positions (may be negative)
// objEnable      in   NUM_OBJ      live per-object enable
// offsetX        out  11           pixelX - topLeftX of the winning object
// offsetY        out  11           pixelY - topLeftY of the winning object
// drawingRequest out  1            some enabled object covers the pixel
// RGBout         out  8            OBJECT_COLOR on hit, else TRANSPARENT_ENCODING
// hitIndex       out  $clog2(NUM_OBJ) (min 1)  index of the winning object
// pixelOverlap   out  1            two or more objects cover this pixel
// frameOverlap   out  NUM_OBJ      objects that overlapped any other object during the previous frame
//
// BEHAVIOUR
// - Clock and reset: single clock clk; resetN is asynchronous, active-low. All outputs and state are cleared on reset.
// - Reset values:
//   - drawingRequest=0, RGBout=8'hFF, offsets=0, hitIndex=0, pixelOverlap=0, frameOverlap=0.
//   - Shadow enables=0, shadow positions=0.
//   - Result: nothing is drawn until the first startOfFrame.
// - Shadow regs: on startOfFrame, topLeftX/Y and objEnable are copied to shadow registers. Only the shadows feed the compares.
// - Stage 1 (registered):
//   - per object i: in[i] = en[i] && pixX>=tlX[i] && pixX<tlX[i]+W && pixY>=tlY[i] && pixY<tlY[i]+H.
//   - The compare uses the shadow values latched up to and including this cycle's startOfFrame.
//   - All add/compare math is signed, 13 bits wide, so no wrap occurs at any 11-bit input.
//   - Per-object offsets are computed and held here.
// - Stage 2 (registered): a priority encoder picks the lowest set i.
//   - Outputs offsets[i], hitIndex=i, drawingRequest=1, RGBout=OBJECT_COLOR.
//   - With no hit: drawingRequest=0, RGBout=8'hFF, offsets=0, hitIndex=0.
//   - pixelOverlap = popcount(in)>=2.
// - Latency: exactly 2 clk from pixelX/Y to all pixel outputs. Throughput is 1 pixel/clk with no stalls.
// - Offsets: truncated to 11 bits unsigned. On a hit they are always within 0..W-1 and 0..H-1.
// - Frame overlap: a sticky accumulator ORs in[] into acc whenever pixelOverlap is asserted.
//   - On startOfFrame: frameOverlap<=acc, then acc<=0.
//   - An overlap event in the same cycle as startOfFrame lands in the new acc, not the published value.
// - Position change with no startOfFrame: has no effect on the outputs.
// - Reset mid-frame: the pipeline flushes immediately, and drawing stays off until the next startOfFrame.
// - Zero-area or fully off-screen object: simply never hits. No special case is needed.
//
// STRUCTURE
// - Package square_obj_pkg:
//   - typedef logic signed [10:0] coord_t;
//   - TRANSPARENT_ENCODING = 8'hFF;
//   - function popcount_ge2().
// - Sub-module bracket_hit: one per object, generated NUM_OBJ times. Holds the shadow regs, the stage-1 compare and the offset calculation.
// - Top level: generate loop, priority encoder, stage-2 regs, overlap accumulator.
//
// TESTING
// 1. Reset, no startOfFrame, obj0 live at (10,10) enabled, pixel (20,20)
//    -> drawingRequest=0, RGBout=FF.
// 2. SOF latch obj0 at (10,10), pixel (20,20)
//    -> 2 clk later drawingRequest=1, offset=(10,10), hitIndex=0.
//    Then pixel (110,20) -> no hit (right edge exclusive).
// 3. obj0 at (-50,-50), pixel (0,0)
//    -> hit, offset=(50,50). Pixel (50,0) -> no hit.
// 4. obj1 at (0,0), obj2 at (50,50), pixel (60,60)
//    -> hitIndex=1, pixelOverlap=1. After the next SOF, frameOverlap=4'b0110.
// 5. Change obj0 topLeft mid-frame without SOF
//    -> outputs are unchanged until SOF, then reflect the new position.
// 6. Assert resetN=0 during a hit
//    -> all outputs go to reset values asynchronously. After release: no draw until SOF, and frameOverlap=0.

Source files
------------

// File: rtl/square_obj_pkg.sv
// Shared types and helpers for the multi-object bracket renderer.
// Coordinates are 11-bit signed VGA values.
package square_obj_pkg;

  typedef logic signed [10:0] coord_t;

  localparam logic [7:0] TRANSPARENT_ENCODING = 8'hFF;

  localparam int MAX_OBJ = 16;

  // True when at least two bits of v are set.
  function automatic logic popcount_ge2(
    input logic [MAX_OBJ-1:0] v
  );
    logic [MAX_OBJ-1:0] one;
    one = {{(MAX_OBJ-1){1'b0}}, 1'b1};
    return |(v & (v - one));
  endfunction

endpackage

// File: rtl/bracket_hit.sv
// One object: frame-start shadow of position/enable,
// registered inside test and pixel offsets.
module bracket_hit
  import square_obj_pkg::*;
#(
  parameter int OBJECT_WIDTH_X  = 100,
  parameter int OBJECT_HEIGHT_Y = 100
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        startOfFrame,
  input  coord_t      pixelX,
  input  coord_t      pixelY,
  input  coord_t      topLeftX,
  input  coord_t      topLeftY,
  input  logic        objEnable,
  output logic        hit,
  output logic [10:0] offsetX,
  output logic [10:0] offsetY
);

  localparam logic signed [12:0] W13 =
    13'(OBJECT_WIDTH_X);
  localparam logic signed [12:0] H13 =
    13'(OBJECT_HEIGHT_Y);

  coord_t sh_x;
  coord_t sh_y;
  logic   sh_en;

  coord_t cur_x;
  coord_t cur_y;
  logic   cur_en;

  logic signed [12:0] px;
  logic signed [12:0] py;
  logic signed [12:0] lx;
  logic signed [12:0] ly;
  logic signed [12:0] rx;
  logic signed [12:0] by;
  logic               in_box;

  // Live values win on the frame-start cycle itself.
  always_comb begin
    cur_x  = startOfFrame ? topLeftX  : sh_x;
    cur_y  = startOfFrame ? topLeftY  : sh_y;
    cur_en = startOfFrame ? objEnable : sh_en;
    px     = {{2{pixelX[10]}}, pixelX};
    py     = {{2{pixelY[10]}}, pixelY};
    lx     = {{2{cur_x[10]}}, cur_x};
    ly     = {{2{cur_y[10]}}, cur_y};
    rx     = lx + W13;
    by     = ly + H13;
    in_box = cur_en
          && (px >= lx) && (px < rx)
          && (py >= ly) && (py < by);
  end

  // Shadow registers, loaded once per frame.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      sh_x  <= '0;
      sh_y  <= '0;
      sh_en <= 1'b0;
    end else if (startOfFrame) begin
      sh_x  <= topLeftX;
      sh_y  <= topLeftY;
      sh_en <= objEnable;
    end
  end

  // Stage 1: hit flag and wrapped offsets.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      hit     <= 1'b0;
      offsetX <= '0;
      offsetY <= '0;
    end else begin
      hit     <= in_box;
      offsetX <= pixelX - cur_x;
      offsetY <= pixelY - cur_y;
    end
  end

endmodule

// File: rtl/multi_square_object.sv
// NUM_OBJ same-size brackets with lowest-index priority,
// per-pixel and per-frame overlap reporting.
module multi_square_object
  import square_obj_pkg::*;
#(
  parameter int         NUM_OBJ         = 4,
  parameter int         OBJECT_WIDTH_X  = 100,
  parameter int         OBJECT_HEIGHT_Y = 100,
  parameter logic [7:0] OBJECT_COLOR    = 8'h03,
  localparam int        IDX_W =
    (NUM_OBJ > 1) ? $clog2(NUM_OBJ) : 1
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               startOfFrame,
  input  coord_t             pixelX,
  input  coord_t             pixelY,
  input  coord_t             topLeftX [NUM_OBJ],
  input  coord_t             topLeftY [NUM_OBJ],
  input  logic [NUM_OBJ-1:0] objEnable,
  output logic [10:0]        offsetX,
  output logic [10:0]        offsetY,
  output logic               drawingRequest,
  output logic [7:0]         RGBout,
  output logic [IDX_W-1:0]   hitIndex,
  output logic               pixelOverlap,
  output logic [NUM_OBJ-1:0] frameOverlap
);

  logic [NUM_OBJ-1:0] hit_s1;
  logic [10:0]        off_x [NUM_OBJ];
  logic [10:0]        off_y [NUM_OBJ];

  logic               win_hit;
  logic [IDX_W-1:0]   win_idx;
  logic [10:0]        win_x;
  logic [10:0]        win_y;
  logic               ov_s1;

  logic [NUM_OBJ-1:0] in_s2;
  logic [NUM_OBJ-1:0] acc;

  for (genvar g = 0; g < NUM_OBJ; g++) begin : g_obj
    bracket_hit #(
      .OBJECT_WIDTH_X  (OBJECT_WIDTH_X),
      .OBJECT_HEIGHT_Y (OBJECT_HEIGHT_Y)
    ) u_hit (
      .clk          (clk),
      .resetN       (resetN),
      .startOfFrame (startOfFrame),
      .pixelX       (pixelX),
      .pixelY       (pixelY),
      .topLeftX     (topLeftX[g]),
      .topLeftY     (topLeftY[g]),
      .objEnable    (objEnable[g]),
      .hit          (hit_s1[g]),
      .offsetX      (off_x[g]),
      .offsetY      (off_y[g])
    );
  end

  // Priority encode: scanning downward, lowest index lands last.
  always_comb begin
    win_hit = 1'b0;
    win_idx = '0;
    win_x   = '0;
    win_y   = '0;
    for (int i = NUM_OBJ - 1; i >= 0; i--) begin
      if (hit_s1[i]) begin
        win_hit = 1'b1;
        win_idx = IDX_W'(i);
        win_x   = off_x[i];
        win_y   = off_y[i];
      end
    end
    ov_s1 = popcount_ge2(MAX_OBJ'(hit_s1));
  end

  // Stage 2: pixel outputs plus overlapping set for the accumulator.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      drawingRequest <= 1'b0;
      RGBout         <= TRANSPARENT_ENCODING;
      offsetX        <= '0;
      offsetY        <= '0;
      hitIndex       <= '0;
      pixelOverlap   <= 1'b0;
      in_s2          <= '0;
    end else begin
      drawingRequest <= win_hit;
      RGBout         <= win_hit ? OBJECT_COLOR
                                : TRANSPARENT_ENCODING;
      offsetX        <= win_x;
      offsetY        <= win_y;
      hitIndex       <= win_idx;
      pixelOverlap   <= ov_s1;
      in_s2          <= ov_s1 ? hit_s1 : '0;
    end
  end

  // Sticky per-frame overlap; publish and restart at frame start.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      acc          <= '0;
      frameOverlap <= '0;
    end else if (startOfFrame) begin
      frameOverlap <= acc;
      acc          <= in_s2;
    end else begin
      acc          <= acc | in_s2;
    end
  end

endmodule
